mem_access_stage: RTL and testbench

//  Consumer end of the EXE/MEM pipeline register. Turns its memread/memwrite/aluout/rdata2 into a
//  req/ack data-memory transaction, stalls the front of the pipe while memory is busy, and registers
//  the MEM/WB result (load data, ALU result or JAL link address) for the writeback stage.

---
 rtl/mem_access_stage_pkg.sv | 35 +++
 rtl/mem_access_stage_mem_wb_reg.sv | 55 +++++
 rtl/mem_access_stage.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage_pkg
//  Purpose  : Shared definitions for the memory-access pipeline stage:
//             default data/address/PC widths, the IDLE/WAIT state encoding
//             and small decode helpers used by the stage control logic.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    // Default widths of the surrounding pipeline
    localparam int c_dsize       = 32;   // data width
    localparam int c_asize       = 5;    // register-file write-address width
    localparam int c_isize       = 32;   // PC / link width
    localparam int c_timeout_cyc = 255;  // default WAIT abort limit

    // Memory-stage control states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // Any instruction that touches data memory
    function automatic logic is_memop(input logic memread, input logic memwrite);
        return memread | memwrite;
    endfunction

    // A store always wins over a load, so load data is never captured for it
    function automatic logic use_load_data(input logic memtoreg, input logic memwrite);
        return memtoreg & ~memwrite;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_mem_wb_reg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_reg
//  Purpose  : MEM/WB pipeline register with asynchronous active-high reset.
//             'load' captures a new writeback result; otherwise 'bubble'
//             clears the write enable so no register-file write happens,
//             while data/address simply hold.
//  Ports    : clk, rst            - clock, async active-high reset
//             load, bubble        - capture / insert-bubble controls
//             data_in, waddr_in,
//             wen_in              - next writeback result
//             data_out, waddr_out,
//             wen_out             - registered MEM/WB outputs
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wb_reg #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             bubble,
    input  logic [DSIZE-1:0] data_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic             wen_in,
    output logic [DSIZE-1:0] data_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic             wen_out
);

    logic [DSIZE-1:0] r_data;
    logic [ASIZE-1:0] r_waddr;
    logic             r_wen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_waddr <= '0;
            r_wen   <= 1'b0;
        end else if (load) begin
            r_data  <= data_in;
            r_waddr <= waddr_in;
            r_wen   <= wen_in;
        end else if (bubble) begin
            r_wen   <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign waddr_out = r_waddr;
    assign wen_out   = r_wen;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : Consumer end of the EXE/MEM register. Converts a load/store
//             into a req/ack data-memory transaction, stalls the front of
//             the pipe while memory is busy, and registers the MEM/WB result
//             (load data, ALU result or JAL link address).
//  Config   : MEM_TIMEOUT_EN - when defined, a WAIT that reaches
//             TIMEOUT_CYC cycles without ack is aborted and the sticky
//             mem_err flag is raised. Undefined: WAIT is unbounded and
//             mem_err is tied low.
//  Ports    : clk, rst                    - clock, async active-high reset
//             aluout_in, rdata2_in,
//             waddr_in, memread_in,
//             memwrite_in, memtoreg_in,
//             wen_in, jal_in, nPC_in      - EXE/MEM register contents
//             dmem_req, dmem_we,
//             dmem_addr, dmem_wdata       - memory request side
//             dmem_ack, dmem_rdata        - memory completion side
//             stall_out                   - freeze upstream pipeline
//             wb_data, wb_waddr, wb_wen   - MEM/WB register outputs
//             mem_err                     - sticky timeout flag
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DSIZE       = c_dsize,
    parameter int ASIZE       = c_asize,
    parameter int ISIZE       = c_isize,
    parameter int TIMEOUT_CYC = c_timeout_cyc
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] aluout_in,
    input  logic [DSIZE-1:0] rdata2_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic             memread_in,
    input  logic             memwrite_in,
    input  logic             memtoreg_in,
    input  logic             wen_in,
    input  logic             jal_in,
    input  logic [ISIZE-1:0] nPC_in,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DSIZE-1:0] dmem_addr,
    output logic [DSIZE-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [DSIZE-1:0] dmem_rdata,
    output logic             stall_out,
    output logic [DSIZE-1:0] wb_data,
    output logic [ASIZE-1:0] wb_waddr,
    output logic             wb_wen,
    output logic             mem_err
);

    mem_state_t       r_state;
    logic             r_req;
    logic             r_we;

    logic             w_memop;
    logic             w_ack_wait;
    logic             w_abort;
    logic             w_load;
    logic             w_bubble;
    logic [DSIZE-1:0] w_link;
    logic [DSIZE-1:0] w_wb_data;

    assign w_memop    = is_memop(memread_in, memwrite_in);
    // Ack is only meaningful while a request is outstanding
    assign w_ack_wait = (r_state == ST_WAIT) & dmem_ack;

    // Link address adapted to the data width (zero-extend or truncate)
    generate
        if (ISIZE >= DSIZE) begin : g_link_trunc
            assign w_link = nPC_in[DSIZE-1:0];
        end else begin : g_link_zext
            assign w_link = {{(DSIZE-ISIZE){1'b0}}, nPC_in};
        end
    endgenerate

`ifdef MEM_TIMEOUT_EN
    localparam int c_cnt_w = ($clog2(TIMEOUT_CYC + 1) < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    // Counter holds (WAIT cycle number - 1), so the limit is hit one below
    localparam logic [c_cnt_w-1:0] c_term_cnt = c_cnt_w'(TIMEOUT_CYC - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;

    // An ack on the terminal cycle is a normal completion, not an abort
    assign w_abort = (r_state == ST_WAIT) & ~dmem_ack & (r_cnt == c_term_cnt);
    assign mem_err = r_err;
`else
    logic w_unused_limit;

    assign w_abort        = 1'b0;
    assign mem_err        = 1'b0;
    assign w_unused_limit = (TIMEOUT_CYC != 0);
`endif

    // Control FSM; request and write-strobe are registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_memop) begin
                        r_state <= ST_WAIT;
                        r_req   <= 1'b1;
                        r_we    <= memwrite_in;
`ifdef MEM_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack || w_abort) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        if (w_abort) begin
                            r_err <= 1'b1;
                        end
`endif
                    end
`ifdef MEM_TIMEOUT_EN
                    else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    // Stall: detecting a memop in IDLE, or waiting for ack. Forced low in
    // reset so the upstream pipe is released immediately.
    always_comb begin
        stall_out = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: stall_out = w_memop;
                ST_WAIT: stall_out = ~dmem_ack & ~w_abort;
                default: stall_out = 1'b0;
            endcase
        end
    end

    // Writeback source: link address beats load data beats ALU result
    always_comb begin
        w_wb_data = aluout_in;
        if (jal_in) begin
            w_wb_data = w_link;
        end else if ((r_state == ST_WAIT) && use_load_data(memtoreg_in, memwrite_in)) begin
            w_wb_data = dmem_rdata;
        end
    end

    // Capture on a pass-through or a completed access; every other cycle
    // (memop detect, waiting, abort) writes a bubble.
    assign w_load   = ((r_state == ST_IDLE) & ~w_memop) | w_ack_wait;
    assign w_bubble = ~w_load;

    mem_wb_reg #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem_wb_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .bubble    (w_bubble),
        .data_in   (w_wb_data),
        .waddr_in  (waddr_in),
        .wen_in    (wen_in),
        .data_out  (wb_data),
        .waddr_out (wb_waddr),
        .wen_out   (wb_wen)
    );

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = aluout_in;
    assign dmem_wdata = rdata2_in;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Self-checking bench for mem_access_stage. Acts as the data
//             memory (word store in an associative array) and predicts the
//             writeback result and handshake of every instruction.
//  Config   : MEM_TIMEOUT_EN - enables the timeout abort scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int IW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] aluout_in, rdata2_in;
    logic [AW-1:0] waddr_in;
    logic          memread_in, memwrite_in, memtoreg_in, wen_in, jal_in;
    logic [IW-1:0] nPC_in;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic          stall_out;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] wb_waddr;
    logic          wb_wen;
    logic          mem_err;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_data;
    logic [4:0]  exp_waddr;
    logic        exp_wen;

    mem_access_stage #(
        .DSIZE(DW), .ASIZE(AW), .ISIZE(IW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .aluout_in(aluout_in), .rdata2_in(rdata2_in), .waddr_in(waddr_in),
        .memread_in(memread_in), .memwrite_in(memwrite_in), .memtoreg_in(memtoreg_in),
        .wen_in(wen_in), .jal_in(jal_in), .nPC_in(nPC_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out),
        .wb_data(wb_data), .wb_waddr(wb_waddr), .wb_wen(wb_wen),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog observed=timeout expected=finish");
            $fatal(1, "bench did not finish");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag);
        check({tag, "_wb_data"}, wb_data, exp_data);
        check({tag, "_wb_waddr"}, {27'd0, wb_waddr}, {27'd0, exp_waddr});
        check({tag, "_wb_wen"}, {31'd0, wb_wen}, {31'd0, exp_wen});
    endtask

    // Memory model: unwritten words read back as a fixed random value
    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        if (!mem.exists(addr)) mem[addr] = $urandom;
        return mem[addr];
    endfunction

    // One instruction through the stage; dly = WAIT cycles before the ack cycle
    task automatic do_op(input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wa,
                         input logic mr, input logic mw, input logic mtr, input logic we,
                         input logic jal, input logic [31:0] npc, input int dly,
                         output int nstall);
        logic        memop;
        logic [31:0] rdata;
        nstall = 0;
        rdata  = '0;
        memop  = mr | mw;
        @(negedge clk);
        aluout_in = alu; rdata2_in = rd2; waddr_in = wa;
        memread_in = mr; memwrite_in = mw; memtoreg_in = mtr;
        wen_in = we; jal_in = jal; nPC_in = npc;
        dmem_ack = 1'($urandom_range(0, 1));     // ack outside WAIT must be ignored
        dmem_rdata = $urandom;
        #1;
        if (!memop) begin
            check("pass_stall", {31'd0, stall_out}, 0);
            check("pass_req", {31'd0, dmem_req}, 0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            exp_data = jal ? npc : alu; exp_waddr = wa; exp_wen = we;
            check_wb("pass");
        end else begin
            check("idle_stall", {31'd0, stall_out}, 1);
            check("idle_req", {31'd0, dmem_req}, 0);
            if (stall_out) nstall++;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            check("bubble_wen", {31'd0, wb_wen}, 0);
            check("req_on", {31'd0, dmem_req}, 1);
            check("req_we", {31'd0, dmem_we}, {31'd0, mw});
            for (int i = 0; i <= dly; i++) begin
                @(negedge clk);
                if (i == dly) begin
                    rdata = mw ? 32'($urandom) : mem_read(alu);
                    dmem_rdata = rdata;
                    dmem_ack = 1'b1;
                end else begin
                    dmem_rdata = $urandom;
                end
                #1;
                if (stall_out) nstall++;
                check("wait_stall", {31'd0, stall_out}, (i == dly) ? 0 : 1);
                if (i == dly) begin
                    check("ack_req", {31'd0, dmem_req}, 1);
                    check("ack_addr", dmem_addr, alu);
                    if (mw) check("ack_wdata", dmem_wdata, rd2);
                end
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                if (i < dly) check("wait_wen", {31'd0, wb_wen}, 0);
            end
            check("req_off", {31'd0, dmem_req}, 0);
            exp_data  = jal ? npc : ((mtr && !mw) ? rdata : alu);
            exp_waddr = wa;
            exp_wen   = we;
            if (mw) mem[alu] = rd2;
            check_wb("mem");
        end
    endtask

    initial begin
        int ns;
        logic [31:0] a, d, n;
        logic [4:0]  wa;
        int kind;

        rst = 1'b1;
        aluout_in = '0; rdata2_in = '0; waddr_in = '0;
        memread_in = 0; memwrite_in = 0; memtoreg_in = 0; wen_in = 0; jal_in = 0;
        nPC_in = '0; dmem_ack = 0; dmem_rdata = '0;
        exp_data = '0; exp_waddr = '0; exp_wen = 1'b0;

        // Reset values
        #2;
        check("rst_req", {31'd0, dmem_req}, 0);
        check("rst_we", {31'd0, dmem_we}, 0);
        check("rst_stall", {31'd0, stall_out}, 0);
        check("rst_err", {31'd0, mem_err}, 0);
        check_wb("rst");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // 1: ALU pass-through
        do_op(32'h1234, 0, 5'd5, 0, 0, 0, 1, 0, 0, 0, ns);
        check("t1_stalls", ns, 0);

        // 2: load, three WAIT cycles before ack
        mem[32'h40] = 32'hDEADBEEF;
        do_op(32'h40, 0, 5'd9, 1, 0, 1, 1, 0, 0, 3, ns);
        check("t2_stalls", ns, 4);
        check("t2_data", wb_data, 32'hDEADBEEF);

        // 3: store acked on first WAIT cycle, wen_in=0
        do_op(32'h80, 32'hA5A5, 5'd3, 0, 1, 0, 0, 0, 0, 0, ns);
        check("t3_stalls", ns, 1);

        // 4: JAL link writeback
        do_op(32'h0, 0, 5'd31, 0, 0, 0, 1, 1, 32'h104, 0, ns);
        check("t4_data", wb_data, 32'h104);

        // Both read and write set: acts as a store, ALU result written back
        do_op(32'h84, 32'h77, 5'd4, 1, 1, 1, 1, 0, 0, 1, ns);
        // Load back what was stored
        do_op(32'h80, 0, 5'd6, 1, 0, 1, 1, 0, 0, 2, ns);
        check("ld_after_st", wb_data, 32'hA5A5);
        do_op(32'h84, 0, 5'd7, 1, 0, 1, 1, 0, 0, 0, ns);
        check("ld_after_both", wb_data, 32'h77);

        // Randomized instruction stream over a small address window
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 4);
            a  = 32'h100 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
            d  = $urandom;
            n  = $urandom;
            wa = 5'($urandom);
            case (kind)
                0: do_op($urandom, d, wa, 0, 0, 0, 1'($urandom), 0, n, 0, ns);
                1: do_op($urandom, d, wa, 0, 0, 0, 1'($urandom), 1, n, 0, ns);
                2: do_op(a, d, wa, 1, 0, 1'($urandom), 1'($urandom), 0, n, $urandom_range(0, 3), ns);
                3: do_op(a, d, wa, 0, 1, 1'($urandom), 1'($urandom), 0, n, $urandom_range(0, 3), ns);
                default: do_op(a, d, wa, 1, 1, 1'($urandom), 1'($urandom), 1'($urandom), n,
                               $urandom_range(0, 3), ns);
            endcase
        end

        // 5: reset in the middle of a WAIT
        @(negedge clk);
        aluout_in = 32'h200; waddr_in = 5'd7; memread_in = 1; memwrite_in = 0;
        memtoreg_in = 1; wen_in = 1; jal_in = 0; dmem_ack = 0;
        @(posedge clk); #1;
        check("t5_req_on", {31'd0, dmem_req}, 1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("t5_req_async", {31'd0, dmem_req}, 0);
        check("t5_stall_async", {31'd0, stall_out}, 0);
        check("t5_wen_async", {31'd0, wb_wen}, 0);
        @(negedge clk);
        rst = 1'b0;
        aluout_in = '0; waddr_in = '0; memread_in = 0; memtoreg_in = 0; wen_in = 0;
        dmem_ack = 1'b1;
        #1;
        check("t5_late_ack_stall", {31'd0, stall_out}, 0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check("t5_late_ack_req", {31'd0, dmem_req}, 0);
        exp_data = '0; exp_waddr = '0; exp_wen = 1'b0;
        check_wb("t5");

`ifdef MEM_TIMEOUT_EN
        // 6: no ack at all, abort on the TMO-th WAIT cycle
        check("t6_err_before", {31'd0, mem_err}, 0);
        @(negedge clk);
        aluout_in = 32'h300; waddr_in = 5'd8; memread_in = 1; memtoreg_in = 1; wen_in = 1;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk); #1;
            check("t6_stall", {31'd0, stall_out}, (i == TMO) ? 0 : 1);
            @(posedge clk); #1;
        end
        check("t6_req_off", {31'd0, dmem_req}, 0);
        check("t6_wen", {31'd0, wb_wen}, 0);
        check("t6_err", {31'd0, mem_err}, 1);
        do_op(32'h55, 0, 5'd2, 0, 0, 0, 1, 0, 0, 0, ns);
        check("t6_err_sticky", {31'd0, mem_err}, 1);
`else
        check("err_tied_low", {31'd0, mem_err}, 0);
`endif

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
